// File: rtl/ssd1306_pkg.sv
// Shared types for the SSD1306 frame scheduler: the scheduler state encoding,
// the default frame size and the byte type used on the framebuffer and driver buses.
// No ports; imported with `import ssd1306_pkg::*`.
package ssd1306_pkg;

  // A 128x32 panel at 1 bpp holds 128*32/8 bytes.
  localparam int FRAME_BYTES_DEFAULT = 512;

  typedef logic [7:0] byte_t;

  // One frame walks SYNC -> (FETCH, LOAD, WRITE)* -> DONE. The *_ACK/*_WAIT pairs
  // follow the driver's ready line down (strobe accepted) and back up (byte or
  // sync fully shifted out).
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SYNC       = 4'd1,
    S_SYNC_ACK   = 4'd2,
    S_SYNC_WAIT  = 4'd3,
    S_FETCH      = 4'd4,
    S_LOAD       = 4'd5,
    S_WRITE      = 4'd6,
    S_WRITE_ACK  = 4'd7,
    S_WRITE_WAIT = 4'd8,
    S_DONE       = 4'd9
  } state_e;

endpackage

// File: rtl/ssd1306_frame_scheduler_if.sv
// Framebuffer-read and display-driver signals of the SSD1306 frame scheduler.
// Latency: framebuffer data returns one cycle after fb_rd_stb_out.
// Backpressure: the driver paces every strobe with drv_ready_in.
// Signals: fb_addr_out/fb_rd_stb_out/fb_data_in (framebuffer read port),
//          drv_data_out/drv_write_stb_out/drv_sync_stb_out/drv_ready_in (driver).
// Modports: master = scheduler side, slave = framebuffer/driver side.
interface ssd1306_frame_scheduler_if
  import ssd1306_pkg::*;
#(
  parameter int ADDR_W = $clog2(FRAME_BYTES_DEFAULT)
);

  logic [ADDR_W-1:0] fb_addr_out;
  logic              fb_rd_stb_out;
  byte_t             fb_data_in;
  byte_t             drv_data_out;
  logic              drv_write_stb_out;
  logic              drv_sync_stb_out;
  logic              drv_ready_in;

  modport master (
    output fb_addr_out,
    output fb_rd_stb_out,
    input  fb_data_in,
    output drv_data_out,
    output drv_write_stb_out,
    output drv_sync_stb_out,
    input  drv_ready_in
  );

  modport slave (
    input  fb_addr_out,
    input  fb_rd_stb_out,
    output fb_data_in,
    input  drv_data_out,
    input  drv_write_stb_out,
    input  drv_sync_stb_out,
    output drv_ready_in
  );

endinterface

// File: rtl/ssd1306_frame_scheduler.sv
// Streams one framebuffer of FRAME_BYTES bytes to an SSD1306 driver per refresh request.
// Latency: frame starts the cycle a request meets enable+ready; each byte costs fetch, load, write plus driver busy time.
// Backpressure: every sync/write strobe waits for drv_ready_in to fall and rise again; extra requests are counted as drops.
// Ports: clk_in, rstn_in (async active-low), enable_in, refresh_tick_in,
//        bus (framebuffer + driver, master modport), busy_out, frame_done_out, drop_cnt_out.
module ssd1306_frame_scheduler
  import ssd1306_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int ADDR_W      = $clog2(FRAME_BYTES)
) (
  input  logic                             clk_in,
  input  logic                             rstn_in,
  input  logic                             enable_in,
  input  logic                             refresh_tick_in,
  ssd1306_frame_scheduler_if.master        bus,
  output logic                             busy_out,
  output logic                             frame_done_out,
  output logic [7:0]                       drop_cnt_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  byte_t             data_q;
  logic              pending_q;
  logic [7:0]        drop_q;

  logic              start;
  logic              last_addr;
  logic              addr_step;

  // A frame starts only from idle with a request outstanding (held or arriving now).
  assign start     = (state_q == S_IDLE) && (pending_q || refresh_tick_in)
                     && enable_in && bus.drv_ready_in;
  assign last_addr = (addr_q == LAST_ADDR);
  // The counter stops at the last byte so it can never wrap inside a frame.
  assign addr_step = (state_q == S_WRITE_WAIT) && bus.drv_ready_in && !last_addr;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start) state_d = S_SYNC;
      S_SYNC:       state_d = S_SYNC_ACK;
      S_SYNC_ACK:   if (!bus.drv_ready_in) state_d = S_SYNC_WAIT;
      S_SYNC_WAIT:  if (bus.drv_ready_in) state_d = S_FETCH;
      S_FETCH:      state_d = S_LOAD;
      S_LOAD:       state_d = S_WRITE;
      S_WRITE:      state_d = S_WRITE_ACK;
      S_WRITE_ACK:  if (!bus.drv_ready_in) state_d = S_WRITE_WAIT;
      S_WRITE_WAIT: begin
        if (bus.drv_ready_in) begin
          state_d = last_addr ? S_DONE : S_FETCH;
        end
      end
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Framebuffer address and driver data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      addr_q <= '0;
    end else if (state_q == S_SYNC) begin
      addr_q <= '0;
    end else if (addr_step) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  // Read data arrives the cycle after the fetch strobe, i.e. during S_LOAD; the
  // captured byte then stays put through the write handshake and beyond.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      data_q <= 8'h00;
    end else if (state_q == S_LOAD) begin
      data_q <= bus.fb_data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh request bookkeeping
  // ---------------------------------------------------------------------------
  // When a frame starts, the outstanding request is consumed. If it was an older
  // held request and a fresh tick lands in that same cycle, the fresh tick becomes
  // the new held request (one follow-up frame). A tick that itself triggers the
  // start is consumed and leaves nothing behind. Any other tick seen while a
  // request is already held has nowhere to go and is counted as dropped.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      pending_q <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      if (start) begin
        pending_q <= pending_q && refresh_tick_in;
      end else if (refresh_tick_in) begin
        pending_q <= 1'b1;
      end

      if (refresh_tick_in && pending_q && !start && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes decode straight from the state register, so a reset forces
  // them low in the same cycle it is asserted.
  // ---------------------------------------------------------------------------
  assign bus.fb_addr_out       = addr_q;
  assign bus.fb_rd_stb_out     = (state_q == S_FETCH);
  assign bus.drv_data_out      = data_q;
  assign bus.drv_sync_stb_out  = (state_q == S_SYNC);
  assign bus.drv_write_stb_out = (state_q == S_WRITE);
  assign busy_out              = (state_q != S_IDLE);
  assign frame_done_out        = (state_q == S_DONE);
  assign drop_cnt_out          = drop_q;

endmodule

// File: tb/tb_ssd1306_frame_scheduler.sv
// Randomized bench for ssd1306_frame_scheduler with a 4-byte frame.
// Framebuffer model answers one cycle after the read strobe; driver model drops
// ready the cycle after any strobe and holds it low for 3 cycles.
module tb_ssd1306_frame_scheduler;

  localparam int NBYTES = 4;

  logic       clk_in = 1'b0;
  logic       rstn_in;
  logic       enable_in;
  logic       refresh_tick_in;
  logic       busy_out;
  logic       frame_done_out;
  logic [7:0] drop_cnt_out;

  ssd1306_frame_scheduler_if #(.ADDR_W(2)) bus ();

  ssd1306_frame_scheduler #(
    .FRAME_BYTES (NBYTES),
    .ADDR_W      (2)
  ) dut (
    .clk_in          (clk_in),
    .rstn_in         (rstn_in),
    .enable_in       (enable_in),
    .refresh_tick_in (refresh_tick_in),
    .bus             (bus),
    .busy_out        (busy_out),
    .frame_done_out  (frame_done_out),
    .drop_cnt_out    (drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  // ---------------------------------------------------------------- models
  logic [7:0] fb_mem [0:NBYTES-1];
  logic [7:0] fb_q = 8'h00;
  int         low_cnt = 0;
  logic       force_low;
  logic       drv_ready;

  assign bus.fb_data_in   = fb_q;
  assign drv_ready        = (low_cnt == 0) && !force_low;
  assign bus.drv_ready_in = drv_ready;

  initial forever begin
    @(posedge clk_in);
    if (bus.fb_rd_stb_out) fb_q <= fb_mem[bus.fb_addr_out];
  end

  initial forever begin
    @(posedge clk_in);
    if (bus.drv_sync_stb_out || bus.drv_write_stb_out) low_cnt <= 3;
    else if (low_cnt != 0) low_cnt <= low_cnt - 1;
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Transaction monitor: counts strobes and checks byte order within each frame.
  int sync_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int proto_err = 0;
  int idx = 0;
  bit in_frame = 1'b0;

  initial forever begin
    @(negedge clk_in);
    if (!rstn_in) begin
      in_frame = 1'b0;
      idx = 0;
    end else begin
      if (bus.drv_sync_stb_out && bus.drv_write_stb_out) proto_err++;
      if (bus.drv_sync_stb_out) begin
        if (in_frame) proto_err++;
        in_frame = 1'b1;
        idx = 0;
        sync_cnt++;
      end
      if (bus.fb_rd_stb_out) chk("fb_addr", bus.fb_addr_out, idx);
      if (bus.drv_write_stb_out) begin
        if (!in_frame || idx >= NBYTES) proto_err++;
        else chk("wr_data", bus.drv_data_out, fb_mem[idx]);
        idx++;
        wr_cnt++;
      end
      if (frame_done_out) begin
        if (!in_frame || idx != NBYTES) proto_err++;
        in_frame = 1'b0;
        done_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic tick();
    refresh_tick_in = 1'b1;
    cyc();
    refresh_tick_in = 1'b0;
  endtask

  task automatic settle();
    repeat (40) cyc();
  endtask

  task automatic wait_sync(input int target, input int budget);
    int n = 0;
    while (sync_cnt < target && n < budget) begin
      cyc();
      n++;
    end
    chk("sync_seen", sync_cnt, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      cyc();
      n++;
    end
    chk("frames_done", done_cnt, target);
  endtask

  task automatic wait_idle_ready();
    int n = 0;
    while ((busy_out || !drv_ready) && n < 200) begin
      cyc();
      n++;
    end
    chk("idle_ready", {30'd0, busy_out, drv_ready}, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  busy_out, 0);
    chk({tag, "_done"},  frame_done_out, 0);
    chk({tag, "_drop"},  drop_cnt_out, 0);
    chk({tag, "_sync"},  bus.drv_sync_stb_out, 0);
    chk({tag, "_write"}, bus.drv_write_stb_out, 0);
    chk({tag, "_rd"},    bus.fb_rd_stb_out, 0);
    chk({tag, "_data"},  bus.drv_data_out, 0);
    chk({tag, "_addr"},  bus.fb_addr_out, 0);
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // ---------------------------------------------------------------- stimulus
  int drop_exp = 0;
  int b_sync, b_wr, b_done, k, nfr;
  bit en_low;

  initial begin
    fb_mem[0] = 8'hA1;
    fb_mem[1] = 8'hB2;
    fb_mem[2] = 8'hC3;
    fb_mem[3] = 8'hD4;
    rstn_in = 1'b0;
    enable_in = 1'b1;
    refresh_tick_in = 1'b0;
    force_low = 1'b0;
    repeat (3) cyc();
    chk_reset_outputs("por");

    // Driver not ready on reset release: request must wait for ready.
    force_low = 1'b1;
    rstn_in = 1'b1;
    cyc();
    tick();
    repeat (10) cyc();
    chk("notready_sync", sync_cnt, 0);
    chk("notready_busy", busy_out, 0);
    force_low = 1'b0;
    wait_done(1, 200);
    settle();
    chk("first_syncs", sync_cnt, 1);
    chk("first_writes", wr_cnt, NBYTES);
    chk("first_busy", busy_out, 0);

    // Random extra ticks during a frame, with enable sometimes dropped mid-frame.
    for (int s = 0; s < 8; s++) begin
      k = $urandom_range(0, 4);
      en_low = 1'($urandom_range(0, 1));
      wait_idle_ready();
      b_sync = sync_cnt;
      b_wr = wr_cnt;
      b_done = done_cnt;
      tick();
      wait_sync(b_sync + 1, 20);
      if (en_low) enable_in = 1'b0;
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(1, 5)) cyc();
        tick();
      end
      wait_done(b_done + 1, 200);
      enable_in = 1'b1;
      nfr = (k > 0) ? 2 : 1;
      if (k > 1) drop_exp = sat255(drop_exp + k - 1);
      wait_done(b_done + nfr, 200);
      settle();
      chk("rnd_syncs", sync_cnt - b_sync, nfr);
      chk("rnd_writes", wr_cnt - b_wr, NBYTES * nfr);
      chk("rnd_drop", drop_cnt_out, drop_exp);
      chk("rnd_busy", busy_out, 0);
    end

    // Tick while disabled: nothing until enable rises.
    enable_in = 1'b0;
    wait_idle_ready();
    b_sync = sync_cnt;
    b_done = done_cnt;
    tick();
    repeat (20) cyc();
    chk("dis_sync", sync_cnt - b_sync, 0);
    chk("dis_busy", busy_out, 0);
    enable_in = 1'b1;
    wait_done(b_done + 1, 200);
    settle();
    chk("dis_frames", sync_cnt - b_sync, 1);

    // 300 ticks during one stretched frame: drop counter saturates.
    wait_idle_ready();
    b_sync = sync_cnt;
    b_done = done_cnt;
    tick();
    wait_sync(b_sync + 1, 20);
    force_low = 1'b1;
    for (int j = 0; j < 300; j++) begin
      tick();
      cyc();
    end
    force_low = 1'b0;
    drop_exp = sat255(drop_exp + 299);
    wait_done(b_done + 2, 300);
    settle();
    chk("sat_drop", drop_cnt_out, drop_exp);
    chk("sat_frames", sync_cnt - b_sync, 2);

    // Reset after the second write of a frame: abandon at once, stay quiet.
    wait_idle_ready();
    b_sync = sync_cnt;
    b_wr = wr_cnt;
    b_done = done_cnt;
    tick();
    begin
      int n = 0;
      while (wr_cnt < b_wr + 2 && n < 200) begin
        cyc();
        n++;
      end
    end
    chk("rst_pre_writes", wr_cnt - b_wr, 2);
    rstn_in = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    drop_exp = 0;
    repeat (3) cyc();
    rstn_in = 1'b1;
    repeat (60) cyc();
    chk("rst_syncs", sync_cnt - b_sync, 1);
    chk("rst_writes", wr_cnt - b_wr, 2);
    chk("rst_dones", done_cnt - b_done, 0);
    chk("rst_busy", busy_out, 0);
    wait_idle_ready();
    tick();
    wait_done(b_done + 1, 200);
    settle();
    chk("post_rst_writes", wr_cnt - b_wr, 2 + NBYTES);
    chk("post_rst_drop", drop_cnt_out, drop_exp);

    chk("protocol_errors", proto_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ssd1306_frame_scheduler.md
SSD1306_FRAME_SCHEDULER -- requirements
Module: ssd1306_frame_scheduler

Interface
REQ-001 Parameter FRAME_BYTES, default 512, is the number of framebuffer bytes streamed per frame (128x32 display, 1 bpp); legal range 2..4096.
REQ-002 Parameter ADDR_W, default $clog2(FRAME_BYTES), is the framebuffer address width.
REQ-003 clk_in  input  1  single clock; all logic rises on posedge.
REQ-004 rstn_in  input  1  reset, asynchronous assert, active-low.
REQ-005 enable_in  input  1  1 = frames may start; 0 = no new frame starts, and the current frame completes.
REQ-006 refresh_tick_in  input  1  one-cycle pulse requesting a frame refresh.
REQ-007 fb_addr_out  output  ADDR_W  framebuffer read address.
REQ-008 fb_rd_stb_out  output  1  framebuffer read strobe; the addressed data is valid on fb_data_in exactly 1 cycle later.
REQ-009 fb_data_in  input  8  framebuffer read data.
REQ-010 drv_data_out  output  8  byte for the driver's data_in.
REQ-011 drv_write_stb_out  output  1  driver write strobe.
REQ-012 drv_sync_stb_out  output  1  driver sync strobe, which returns the display to (0,0).
REQ-013 drv_ready_in  input  1  driver ready_out.
REQ-014 busy_out  output  1  high whenever the state is not S_IDLE.
REQ-015 frame_done_out  output  1  one-cycle pulse when the last byte of a frame has been accepted.
REQ-016 drop_cnt_out  output  8  saturating count of refresh requests that were dropped.

Function
REQ-017 The state set SHALL be: S_IDLE, S_SYNC, S_SYNC_ACK, S_SYNC_WAIT, S_FETCH, S_LOAD, S_WRITE, S_WRITE_ACK, S_WRITE_WAIT, S_DONE.
REQ-018 A pending flag SHALL set on refresh_tick_in and clear when S_IDLE leaves for S_SYNC.
REQ-019 A refresh_tick_in arriving while pending is already set SHALL increment drop_cnt_out, saturating at 255.
REQ-020 S_IDLE SHALL go to S_SYNC when (pending or refresh_tick_in) and enable_in and drv_ready_in; otherwise it SHALL stay in S_IDLE.
REQ-021 S_SYNC SHALL assert drv_sync_stb_out for exactly 1 cycle, clear the address counter to 0, and go to S_SYNC_ACK.
REQ-022 S_SYNC_ACK SHALL wait for drv_ready_in=0, then go to S_SYNC_WAIT.
REQ-023 S_SYNC_WAIT SHALL wait for drv_ready_in=1, then go to S_FETCH.
REQ-024 S_FETCH SHALL assert fb_rd_stb_out for 1 cycle with fb_addr_out equal to the address counter.
REQ-025 S_LOAD SHALL register fb_data_in into drv_data_out.
REQ-026 S_WRITE SHALL assert drv_write_stb_out for 1 cycle, then go to S_WRITE_ACK.
REQ-027 S_WRITE_ACK SHALL wait for drv_ready_in=0, then go to S_WRITE_WAIT.
REQ-028 S_WRITE_WAIT, on drv_ready_in=1, SHALL go to S_DONE if the address equals FRAME_BYTES-1; otherwise it SHALL increment the address and go to S_FETCH.
REQ-029 S_DONE SHALL pulse frame_done_out for 1 cycle and go to S_IDLE.
REQ-030 drv_sync_stb_out and drv_write_stb_out SHALL never be high in the same cycle, and each SHALL be high only in its own strobe state.
REQ-031 drv_data_out SHALL hold its value from S_LOAD until the next S_LOAD.
REQ-032 Deasserting enable_in mid-frame SHALL NOT abort the frame.
REQ-033 A refresh_tick_in in the same cycle that S_IDLE leaves SHALL set pending, so exactly one follow-up frame runs.
REQ-034 The address counter SHALL never exceed FRAME_BYTES-1 and SHALL NOT wrap within a frame.

Reset
REQ-035 While rstn_in=0: state = S_IDLE; address = 0; pending = 0; drop_cnt_out = 0; drv_data_out = 8'h00; all strobes = 0; busy_out = 0; frame_done_out = 0.
REQ-036 An asynchronous reset mid-frame SHALL abandon the frame immediately and issue no further strobes.
REQ-037 After release, the first frame SHALL start only once drv_ready_in=1.

Structure
REQ-038 The state enum and the default FRAME_BYTES SHALL live in shared package ssd1306_pkg.
REQ-039 The block SHALL be a single module with no sub-module.
REQ-040 Strobe outputs SHALL be decoded from the state register; the data and address outputs SHALL be registered.

Verification
All scenarios use FRAME_BYTES=4, framebuffer contents {8'hA1, 8'hB2, 8'hC3, 8'hD4}, and a driver model whose ready drops 1 cycle after any strobe and stays low 3 cycles.
REQ-041 One tick with enable_in=1 -> 1 sync strobe, then 4 write strobes carrying A1, B2, C3, D4 in order, then 1 frame_done pulse; busy_out returns to 0.
REQ-042 A tick during the frame, then another tick -> exactly 2 frames total; drop_cnt_out=1.
REQ-043 300 ticks during a single frame -> drop_cnt_out=255, saturated.
REQ-044 Tick while enable_in=0, then raise enable_in 20 cycles later -> the frame starts only after the raise.
REQ-045 Reset asserted after the 2nd write strobe -> all outputs at reset values the same cycle; no further strobes until a new tick.
REQ-046 Tick while the model holds drv_ready_in=0 for 10 cycles -> no sync strobe until drv_ready_in=1.
